systolic_tile_ctrl: RTL and testbench
=====================================

Name: systolic_tile_ctrl

Overview:
- Per-tile sequencer for the N x N weight-stationary systolic array.
- Configures active columns and streams N weight rows north with accept_w.
- Issues per-row skewed valid/switch for M input rows, then counts south-edge results to tile completion.
- Sits between the unified-buffer read side and the array. Carries control only; data muxing is driven by this block's read strobes/indices.

Parameters:
- N, 16, array width/height (matches SYSTOLIC_ARRAY_WIDTH)
- CNT_W, 16, width of row/column counters and config fields

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (asserted at 0)
- start_in  in  1  one-cycle tile start; sampled only in IDLE
- col_size_in  in  CNT_W  active columns K, legal 1..N
- row_count_in  in  CNT_W  input rows M, legal 1..2^CNT_W-1
- busy_out  out  1  high in any state other than IDLE
- done_out  out  1  one-cycle pulse on tile completion
- err_out  out  1  one-cycle pulse on an illegal config
- ub_rd_col_size_out  out  CNT_W  latched K
- ub_rd_col_size_valid_out  out  1  one-cycle config strobe
- w_rd_en_out  out  1  weight row read strobe
- w_rd_row_out  out  CNT_W  weight row index 0..N-1
- sys_accept_w_out  out  N  per-column weight accept
- a_rd_en_out  out  N  per-array-row input read strobe, equal to sys_valid_out
- stream_cycle_out  out  CNT_W  stream-phase cycle t; row i reads A[t-i][i]
- sys_valid_out  out  N  per-row skewed valid into the west edge
- sys_switch_out  out  N  per-row skewed switch pulse
- sys_valid_in  in  N  south-edge valid from the array

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- IDLE -> CFG on start_in with legal K and M. Latch K and M.
- Illegal K (0 or >N) or M=0: pulse err_out for 1 cycle, stay IDLE, no other output toggles.
- CFG, 1 cycle:
  - ub_rd_col_size_out=K and ub_rd_col_size_valid_out=1.
  - Next state LOAD_W.
- LOAD_W, exactly N cycles, k=0..N-1:
  - w_rd_en_out=1 and w_rd_row_out=k.
  - sys_accept_w_out[j]=1 for j<K, 0 otherwise.
  - Then go to STREAM with t=0.
  - No bubble between the last weight cycle and t=0.
- STREAM, exactly M+N-1 cycles, t=0..M+N-2:
  - sys_valid_out[i] = (t>=i) && (t<i+M).
  - sys_switch_out[i]=1 only at t==i. The switch coincides with the row's first valid.
  - stream_cycle_out=t. Outside STREAM it holds 0.
- DRAIN:
  - Count sys_valid_in[K-1] pulses, starting from STREAM entry, so early arrivals are counted.
  - When the count equals M, go to DONE.
  - Pulses on columns >=K are ignored.
- DONE, 1 cycle: done_out=1, then IDLE.
- Counter widths: count width CNT_W+1 so M+N-1 does not overflow.
- The last K-1 result can arrive in the same cycle as the STREAM->DRAIN transition. That cycle is counted.
- start_in while busy_out=1 is ignored and not queued.
- Reset mid-tile: all outputs drop asynchronously to 0 and the FSM returns to IDLE. No done or err pulse.

Optional Feature:
- Macro SYSTOLIC_TILE_CTRL_TIMEOUT_EN.
- When defined, a DRAIN watchdog counts cycles spent in DRAIN.
- If the count reaches 4*N with the result count still below M:
  - pulse err_out for 1 cycle together with done_out;
  - return to IDLE.
- When undefined, DRAIN waits indefinitely and err_out flags illegal config only.

Test Plan:
- N=4, K=4, M=3, start -> CFG strobe with size 4.
  - 4 LOAD_W cycles, rows 0..3, accept_w=4'b1111.
  - STREAM 6 cycles; row 2 valid at t=2..4, switch[2] only at t=2.
  - Model returns 3 col-3 valids -> done_out 1 cycle later.
- K=2, M=1 -> accept_w=4'b0011. Only sys_valid_in[1] pulses are counted. A col-3 pulse mid-drain does not complete the tile.
- K=0, then K=5, then M=0 -> err_out pulse each time, busy_out stays 0, no CFG strobe.
- start_in asserted during LOAD_W -> ignored. Exactly one done_out for the tile.
- rst=0 at STREAM t=2 -> all outputs 0 immediately. After release, a new start runs a full clean tile.
- TIMEOUT_EN defined, model withholds the last result -> err_out and done_out together after 16 DRAIN cycles (N=4), FSM in IDLE.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// Per-tile sequencer for the weight-stationary systolic array.
// Optional DRAIN watchdog: define SYSTOLIC_TILE_CTRL_TIMEOUT_EN.
module systolic_tile_ctrl #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [CNT_W-1:0] col_size_in,
  input  logic [CNT_W-1:0] row_count_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out,
  output logic [CNT_W-1:0] ub_rd_col_size_out,
  output logic             ub_rd_col_size_valid_out,
  output logic             w_rd_en_out,
  output logic [CNT_W-1:0] w_rd_row_out,
  output logic [N-1:0]     sys_accept_w_out,
  output logic [N-1:0]     a_rd_en_out,
  output logic [CNT_W-1:0] stream_cycle_out,
  output logic [N-1:0]     sys_valid_out,
  output logic [N-1:0]     sys_switch_out,
  input  logic [N-1:0]     sys_valid_in
);

  localparam int CW = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] k_q, m_q;
  logic [CW-1:0]    cnt_q, res_q, res_next, last_t;
  logic             err_q, err_d;
  logic             cfg_ok, hit;

`ifdef SYSTOLIC_TILE_CTRL_TIMEOUT_EN
  logic [CW-1:0]    wd_q;
`endif

  assign cfg_ok = (col_size_in != '0)
               && (col_size_in <= CNT_W'(N))
               && (row_count_in != '0);

  assign last_t = CW'(m_q) + CW'(N) - CW'(2);

  // Only the rightmost active column reports tile results.
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < N; j++)
      if (k_q == CNT_W'(j + 1))
        hit = sys_valid_in[j];
  end

  assign res_next = res_q + CW'(hit);

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_in && cfg_ok)
          state_d = S_CFG;
        else if (start_in)
          err_d = 1'b1;
      end
      S_CFG:
        state_d = S_LOAD_W;
      S_LOAD_W:
        if (cnt_q == CW'(N - 1))
          state_d = S_STREAM;
      S_STREAM:
        if (cnt_q == last_t)
          state_d = S_DRAIN;
      S_DRAIN: begin
        if (res_next >= CW'(m_q))
          state_d = S_DONE;
`ifdef SYSTOLIC_TILE_CTRL_TIMEOUT_EN
        else if (wd_q == CW'(4 * N - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      if (state == S_IDLE && start_in && cfg_ok) begin
        k_q <= col_size_in;
        m_q <= row_count_in;
      end
      if (state_d != state)
        cnt_q <= '0;
      else if (state == S_LOAD_W || state == S_STREAM)
        cnt_q <= cnt_q + CW'(1);
      if (state == S_CFG)
        res_q <= '0;
      else if (state == S_STREAM || state == S_DRAIN)
        res_q <= res_next;
    end
  end

`ifdef SYSTOLIC_TILE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wd_q <= '0;
    else if (state == S_DRAIN)
      wd_q <= wd_q + CW'(1);
    else
      wd_q <= '0;
  end
`endif

  assign busy_out = (state != S_IDLE);
  assign done_out = (state == S_DONE);
  assign err_out  = err_q;

  assign ub_rd_col_size_valid_out = (state == S_CFG);
  assign ub_rd_col_size_out =
    (state == S_CFG) ? k_q : '0;

  assign w_rd_en_out  = (state == S_LOAD_W);
  assign w_rd_row_out =
    (state == S_LOAD_W) ? cnt_q[CNT_W-1:0] : '0;

  assign stream_cycle_out =
    (state == S_STREAM) ? cnt_q[CNT_W-1:0] : '0;

  // Row i sees M valids starting at t == i; switch marks the first.
  always_comb begin
    sys_accept_w_out = '0;
    sys_valid_out    = '0;
    sys_switch_out   = '0;
    for (int j = 0; j < N; j++) begin
      if (state == S_LOAD_W)
        sys_accept_w_out[j] = (CNT_W'(j) < k_q);
      if (state == S_STREAM) begin
        sys_valid_out[j] = (cnt_q >= CW'(j))
                        && (cnt_q < CW'(j) + CW'(m_q));
        sys_switch_out[j] = (cnt_q == CW'(j));
      end
    end
  end

  assign a_rd_en_out = sys_valid_out;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Randomized self-checking bench for systolic_tile_ctrl (N=4).
// Expected outputs come from per-cycle tile-phase arithmetic.
module tb_systolic_tile_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int VW    = 69;

  logic             clk;
  logic             rst;
  logic             start_in;
  logic [CNT_W-1:0] col_size_in;
  logic [CNT_W-1:0] row_count_in;
  logic             busy_out;
  logic             done_out;
  logic             err_out;
  logic [CNT_W-1:0] ub_rd_col_size_out;
  logic             ub_rd_col_size_valid_out;
  logic             w_rd_en_out;
  logic [CNT_W-1:0] w_rd_row_out;
  logic [N-1:0]     sys_accept_w_out;
  logic [N-1:0]     a_rd_en_out;
  logic [CNT_W-1:0] stream_cycle_out;
  logic [N-1:0]     sys_valid_out;
  logic [N-1:0]     sys_switch_out;
  logic [N-1:0]     sys_valid_in;

  int tests;
  int fails;

  systolic_tile_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start_in                 (start_in),
    .col_size_in              (col_size_in),
    .row_count_in             (row_count_in),
    .busy_out                 (busy_out),
    .done_out                 (done_out),
    .err_out                  (err_out),
    .ub_rd_col_size_out       (ub_rd_col_size_out),
    .ub_rd_col_size_valid_out (ub_rd_col_size_valid_out),
    .w_rd_en_out              (w_rd_en_out),
    .w_rd_row_out             (w_rd_row_out),
    .sys_accept_w_out         (sys_accept_w_out),
    .a_rd_en_out              (a_rd_en_out),
    .stream_cycle_out         (stream_cycle_out),
    .sys_valid_out            (sys_valid_out),
    .sys_switch_out           (sys_switch_out),
    .sys_valid_in             (sys_valid_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] obs;
  assign obs = {busy_out, done_out, err_out,
                ub_rd_col_size_valid_out, ub_rd_col_size_out,
                w_rd_en_out, w_rd_row_out, sys_accept_w_out,
                a_rd_en_out, stream_cycle_out,
                sys_valid_out, sys_switch_out};

  // Expected outputs at cycle o after the start cycle (o=0).
  function automatic logic [VW-1:0] expv(
    input int o, input int k, input int m,
    input int done_o, input bit err_at);
    logic             b, d, e, cv, we;
    logic [CNT_W-1:0] cs, wr, sc;
    logic [N-1:0]     acc, v, sw;
    int               t;
    b = (o >= 1) && (o <= done_o);
    d = (o == done_o);
    e = err_at && (o == done_o);
    cv = (o == 1);
    cs = (o == 1) ? CNT_W'(k) : '0;
    we = (o >= 2) && (o <= N + 1);
    wr = we ? CNT_W'(o - 2) : '0;
    acc = '0;
    v = '0;
    sw = '0;
    sc = '0;
    for (int j = 0; j < N; j++)
      if (we && j < k) acc[j] = 1'b1;
    t = o - N - 2;
    if (t >= 0 && t <= m + N - 2) begin
      sc = CNT_W'(t);
      for (int i = 0; i < N; i++) begin
        v[i]  = (t >= i) && (t < i + m);
        sw[i] = (t == i);
      end
    end
    return {b, d, e, cv, cs, we, wr, acc, v, sc, v, sw};
  endfunction

  task automatic run_tile(input string name, input int k,
                          input int m, input int extra_o,
                          input bit withhold);
    bit pulse [0:255];
    int p, np, drain_o, done_o;
    bit err_at;
    logic [VW-1:0] e;
    logic [N-1:0] noise;
    for (int i = 0; i < 256; i++) pulse[i] = 1'b0;
    np = withhold ? m - 1 : m;
    p = N + 2 + $urandom_range(0, 3);
    for (int r = 0; r < np; r++) begin
      pulse[p] = 1'b1;
      if (r < np - 1) p = p + $urandom_range(1, 3);
    end
    drain_o = 2 * N + m + 1;
    done_o = ((p > drain_o) ? p : drain_o) + 1;
    err_at = 1'b0;
    if (withhold) begin
      done_o = drain_o + 4 * N;
      err_at = 1'b1;
    end
    for (int o = 0; o <= done_o + 1; o++) begin
      @(posedge clk);
      #1;
      start_in = (o == 0) || (o == extra_o);
      if (o == 0) begin
        col_size_in  = CNT_W'(k);
        row_count_in = CNT_W'(m);
      end
      noise = N'($urandom & $urandom);
      noise = noise & ~(N'(1) << (k - 1));
      sys_valid_in = noise;
      if (pulse[o]) sys_valid_in[k-1] = 1'b1;
      e = expv(o, k, m, done_o, err_at);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s o=%0d got=%h exp=%h",
                 name, o, obs, e);
      end
    end
    start_in = 1'b0;
    sys_valid_in = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start_in = 1'b0;
    col_size_in = '0;
    row_count_in = '0;
    sys_valid_in = '0;
    #3;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset got=%h exp=0", obs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_illegal(input string name,
                              input int k, input int m);
    logic [VW-1:0] e;
    @(posedge clk);
    #1;
    start_in = 1'b1;
    col_size_in = CNT_W'(k);
    row_count_in = CNT_W'(m);
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL %s_start got=%h exp=0", name, obs);
    end
    @(posedge clk);
    #1;
    start_in = 1'b0;
    e = '0;
    e[VW-3] = 1'b1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL %s_err got=%h exp=%h", name, obs, e);
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL %s_after got=%h exp=0", name, obs);
    end
  endtask

  task automatic test_mid_reset;
    @(posedge clk);
    #1;
    start_in = 1'b1;
    col_size_in = CNT_W'(4);
    row_count_in = CNT_W'(3);
    for (int o = 1; o <= N + 4; o++) begin
      @(posedge clk);
      #1;
      start_in = 1'b0;
    end
    tests++;
    if (stream_cycle_out !== CNT_W'(2)) begin
      fails++;
      $display("FAIL mid_reset_t got=%0d exp=2",
               stream_cycle_out);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL mid_reset_drop got=%h exp=0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    run_tile("after_reset", 3, 4, -1, 1'b0);
  endtask

  task automatic test_random;
    int k, m;
    for (int n = 0; n < 10; n++) begin
      k = $urandom_range(1, N);
      m = $urandom_range(1, 10);
      run_tile("random", k, m, -1, 1'b0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    run_tile("basic_k4_m3", 4, 3, -1, 1'b0);
    run_tile("narrow_k2_m1", 2, 1, -1, 1'b0);
    test_illegal("k0", 0, 3);
    test_illegal("k5", 5, 3);
    test_illegal("m0", 2, 0);
    run_tile("start_in_load", 3, 2, 3, 1'b0);
    run_tile("start_in_drain", 1, 5, 2 * N + 6, 1'b0);
    test_mid_reset();
    test_random();
`ifdef SYSTOLIC_TILE_CTRL_TIMEOUT_EN
    run_tile("timeout", 4, 3, -1, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
